ising_problem_loader: RTL

ISING_PROBLEM_LOADER -- requirements
Module: ising_problem_loader

---
 rtl/ising_problem_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ising_problem_loader.sv
// Ising problem loader: writes counter config, coupling weights and optional
// local-field weights into the annealer, runs it for a programmed number of
// cycles, then reads back phases and thresholds them into spin bits.
module ising_problem_loader #(
  parameter int          N                = 8,
  parameter int          NUM_WEIGHTS      = 3,
  parameter logic [31:0] WEIGHT_ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] PHASE_ADDR_BASE  = 32'h0010_0000,
  parameter logic [31:0] START_ADDR       = 32'h0020_0000,
  parameter logic [31:0] CTR_CUTOFF_ADDR  = 32'h0020_0004,
  parameter logic [31:0] CTR_MAX_ADDR     = 32'h0020_0008
) (
  input  logic                   clk,
  input  logic                   axi_rstn,
  input  logic                   go,
  output logic                   busy,
  output logic                   done,
  input  logic [31:0]            cfg_cutoff,
  input  logic [31:0]            cfg_max,
  input  logic [31:0]            cfg_run_cycles,
  input  logic [NUM_WEIGHTS-1:0] cfg_field_w,
  input  logic                   cfg_field_en,
  input  logic                   edge_valid,
  output logic                   edge_ready,
  input  logic [$clog2(N)-1:0]   edge_i,
  input  logic [$clog2(N)-1:0]   edge_j,
  input  logic [NUM_WEIGHTS-1:0] edge_w,
  input  logic                   edge_last,
  output logic                   m_wready,
  output logic [31:0]            m_wr_addr,
  output logic [31:0]            m_wdata,
  output logic [31:0]            m_araddr,
  input  logic [31:0]            m_rdata,
  output logic [N-1:0]           spins,
  output logic                   err
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] N_CNT        = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_K       = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FIELD_LAST_K = CNT_W'(N - 2);

  typedef enum logic [3:0] {
    IDLE, CFG_CUT, CFG_MAX, EDGE_WAIT, EDGE_IJ, EDGE_JI, FIELD_IH, FIELD_HI,
    START, RUN, STOP, RD_ADDR, RD_CAP, DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [31:0]            cut_q, max_q, run_q, run_cnt;
  logic [NUM_WEIGHTS-1:0] field_w_q, ew;
  logic                   field_en_q, elast;
  logic [CNT_W-1:0]       ei, ej, k;
  logic [N-1:0]           spin_buf;
  logic                   edge_bad;

  assign edge_bad = ({1'b0, edge_i} >= N_CNT) || ({1'b0, edge_j} >= N_CNT);

  function automatic logic [31:0] weight_addr(input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] j);
    return WEIGHT_ADDR_BASE + (32'(i) << 2) + (32'(j) << 13);
  endfunction

  function automatic state_t after_edge(input logic last_flag, input logic field_en);
    if (!last_flag) return EDGE_WAIT;
    else if (field_en) return FIELD_IH;
    else return START;
  endfunction

  // State register, forced to IDLE by reset
  always_ff @(posedge clk) begin
    if (!axi_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state decode and per-state bus outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    edge_ready = 1'b0;
    m_wready   = 1'b0;
    m_wr_addr  = 32'd0;
    m_wdata    = 32'd0;
    m_araddr   = 32'd0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = CFG_CUT;
      end
      CFG_CUT: begin
        m_wready  = 1'b1;
        m_wr_addr = CTR_CUTOFF_ADDR;
        m_wdata   = cut_q;
        state_nxt = CFG_MAX;
      end
      CFG_MAX: begin
        m_wready  = 1'b1;
        m_wr_addr = CTR_MAX_ADDR;
        m_wdata   = max_q;
        state_nxt = EDGE_WAIT;
      end
      EDGE_WAIT: begin
        edge_ready = 1'b1;
        if (edge_valid) begin
          if (edge_bad) state_nxt = after_edge(edge_last, field_en_q);
          else          state_nxt = EDGE_IJ;
        end
      end
      EDGE_IJ: begin
        m_wready  = 1'b1;
        m_wr_addr = weight_addr(ei, ej);
        m_wdata   = 32'(ew);
        state_nxt = (ei == ej) ? after_edge(elast, field_en_q) : EDGE_JI;
      end
      EDGE_JI: begin
        m_wready  = 1'b1;
        m_wr_addr = weight_addr(ej, ei);
        m_wdata   = 32'(ew);
        state_nxt = after_edge(elast, field_en_q);
      end
      FIELD_IH: begin
        m_wready  = 1'b1;
        m_wr_addr = weight_addr(k, LAST_K);
        m_wdata   = 32'(field_w_q);
        state_nxt = FIELD_HI;
      end
      FIELD_HI: begin
        m_wready  = 1'b1;
        m_wr_addr = weight_addr(LAST_K, k);
        m_wdata   = 32'(field_w_q);
        state_nxt = (k == FIELD_LAST_K) ? START : FIELD_IH;
      end
      START: begin
        m_wready  = 1'b1;
        m_wr_addr = START_ADDR;
        m_wdata   = 32'd1;
        state_nxt = RUN;
      end
      RUN: begin
        if (run_cnt <= 32'd1) state_nxt = STOP;
      end
      STOP: begin
        m_wready  = 1'b1;
        m_wr_addr = START_ADDR;
        m_wdata   = 32'd0;
        state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        m_araddr  = PHASE_ADDR_BASE + (32'(k) << 2);
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        state_nxt = (k == LAST_K) ? DONE : RD_ADDR;
      end
      DONE: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: config capture, edge capture, counters, readback and flags
  always_ff @(posedge clk) begin
    if (!axi_rstn) begin
      cut_q      <= '0;
      max_q      <= '0;
      run_q      <= '0;
      run_cnt    <= '0;
      field_w_q  <= '0;
      field_en_q <= 1'b0;
      ei         <= '0;
      ej         <= '0;
      ew         <= '0;
      elast      <= 1'b0;
      k          <= '0;
      spin_buf   <= '0;
      spins      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (go) begin
            cut_q      <= cfg_cutoff;
            max_q      <= cfg_max;
            run_q      <= cfg_run_cycles;
            field_w_q  <= cfg_field_w;
            field_en_q <= cfg_field_en;
            err        <= 1'b0;
            k          <= '0;
          end
        end
        EDGE_WAIT: begin
          if (edge_valid) begin
            if (edge_bad) begin
              err <= 1'b1;
            end else begin
              ei    <= {1'b0, edge_i};
              ej    <= {1'b0, edge_j};
              ew    <= edge_w;
              elast <= edge_last;
            end
          end
        end
        FIELD_HI: k <= (k == FIELD_LAST_K) ? '0 : k + 1'b1;
        START:    run_cnt <= (run_q == 32'd0) ? 32'd1 : run_q;
        RUN:      run_cnt <= run_cnt - 32'd1;
        RD_CAP: begin
          spin_buf[k[IDX_W-1:0]] <= (m_rdata >= cut_q);
          k                      <= k + 1'b1;
        end
        DONE:     spins <= spin_buf;
        default: ;
      endcase
    end
  end

endmodule
